// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath and its argmax decision stage:
// widths, state encodings and fp32 field constants.
package softmax_pkg;

    localparam int DATALENGTH = 32;
    localparam int INPUTMAX   = 5;
    localparam int BUFDEPTH   = 1 << INPUTMAX;

    localparam int SIGN    = 31;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        INPUTSTREAM  = 2'd1,
        OP           = 2'd2,
        OUTPUTSTREAM = 2'd3
    } softmaxState_t;

    typedef enum logic [1:0] {
        ARGMAX_IDLE = 2'd0,
        COLLECT     = 2'd1,
        DONE        = 2'd2
    } argmaxState_t;

endpackage

// File: rtl/softmax_argmax_fp32_pos_gt.sv
// Combinational fp32 compare: gt is set when a is a non-NaN, sign-clear value
// whose magnitude is strictly above b.
module fp32_pos_gt
    import softmax_pkg::*;
(
    input  logic [DATALENGTH-1:0] a,
    input  logic [DATALENGTH-1:0] b,
    output logic                  gt,
    output logic                  a_nan,
    output logic                  a_neg
);

    // A negative running max never occurs in practice, but any positive sample beats one.
    always_comb begin
        a_nan = (a[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (a[EXP_LSB-1:0] != '0);
        a_neg = a[SIGN];
        gt    = !a_nan && !a_neg && (b[SIGN] || (a[SIGN-1:0] > b[SIGN-1:0]));
    end

endmodule

// File: rtl/softmax_argmax.sv
// Argmax over a stream of N fp32 softmax probabilities, with a Done strobe and error flag.
// Optional sample buffer with registered read port when SOFTMAX_ARGMAX_BUF_EN is defined.
module softmax_argmax
    import softmax_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  InValid,
    input  logic [DATALENGTH-1:0] Datain,
    input  logic [INPUTMAX-1:0]   N,
    output logic                  Done,
    output logic [INPUTMAX-1:0]   ArgMax,
    output logic [DATALENGTH-1:0] MaxVal,
    output logic                  Error
`ifdef SOFTMAX_ARGMAX_BUF_EN
    ,
    input  logic [INPUTMAX-1:0]   ReadAddr,
    output logic [DATALENGTH-1:0] ReadData
`endif
);

    localparam logic [INPUTMAX-1:0] ONE = INPUTMAX'(1);

    argmaxState_t state, nextState;

    logic [INPUTMAX-1:0]   count;
    logic [INPUTMAX-1:0]   idx;
    logic [INPUTMAX-1:0]   curIdx;
    logic [DATALENGTH-1:0] baseMax;
    logic                  accept;
    logic                  lastSample;
    logic                  sampleGt;
    logic                  sampleNan;
    logic                  sampleNeg;

    // A Start cycle behaves as if the vector had just been cleared, so the
    // sample arriving with it is compared against zero as index 0.
    always_comb begin
        curIdx     = Start ? '0 : idx;
        baseMax    = Start ? '0 : MaxVal;
        accept     = InValid && (Start ? (N != '0) : (state == COLLECT));
        lastSample = Start ? (N == ONE) : ((idx + ONE) == count);
    end

    fp32_pos_gt u_cmp (
        .a     (Datain),
        .b     (baseMax),
        .gt    (sampleGt),
        .a_nan (sampleNan),
        .a_neg (sampleNeg)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= ARGMAX_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (Start) begin
            nextState = ((N == '0) || (accept && lastSample)) ? DONE : COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && lastSample) nextState = DONE;
                DONE:    nextState = ARGMAX_IDLE;
                default: nextState = state;
            endcase
        end
    end

    always_comb begin
        Done = (state == DONE);
    end

    // Results are only cleared by Start or Reset so they hold after Done.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count  <= '0;
            idx    <= '0;
            MaxVal <= '0;
            ArgMax <= '0;
            Error  <= 1'b0;
        end else begin
            if (Start) begin
                count  <= N;
                idx    <= '0;
                MaxVal <= '0;
                ArgMax <= '0;
                Error  <= (N == '0);
            end
            if (accept) begin
                idx <= curIdx + ONE;
                if (sampleNan || sampleNeg) Error <= 1'b1;
                if (sampleGt) begin
                    MaxVal <= Datain;
                    ArgMax <= curIdx;
                end
            end
        end
    end

`ifdef SOFTMAX_ARGMAX_BUF_EN
    logic [DATALENGTH-1:0] sampleBuf [BUFDEPTH];

    always_ff @(posedge Clock) begin
        if (!Reset && accept) sampleBuf[curIdx] <= Datain;
    end

    always_ff @(posedge Clock) begin
        if (Reset) ReadData <= '0;
        else       ReadData <= sampleBuf[ReadAddr];
    end
`endif

endmodule
